// File: rtl/maquina_lectura_pkg.sv
// Shared constants and state encoding for the RTC read sequencer.
package maquina_lectura_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_READ,
    S_DONE
  } estado_t;

  localparam logic [7:0] ADDR_TRANSF = 8'hF0;
  localparam logic [7:0] CLK_BASE    = 8'h21;
  localparam logic [7:0] TMR_BASE    = 8'h41;

  localparam logic [3:0] IDX_ULT_CLK = 4'd5;
  localparam logic [3:0] IDX_ULT_TMR = 4'd8;
  localparam int         N_REGS      = 9;

endpackage

// File: rtl/maquina_lectura_tabla_dir.sv
// Index to RTC register address lookup for the read sequence.
module tabla_dir_lectura
  import maquina_lectura_pkg::*;
#(
  parameter logic [7:0] P_CLK_BASE = CLK_BASE,
  parameter logic [7:0] P_TMR_BASE = TMR_BASE
) (
  input  logic [3:0] i_idx,
  output logic [7:0] o_addr
);

  logic [7:0] w_idx8;

  assign w_idx8 = {4'b0000, i_idx};

  always_comb begin
    o_addr = P_CLK_BASE;
    unique case (1'b1)
      (i_idx < 4'd6):
        o_addr = P_CLK_BASE + w_idx8;
      (i_idx >= 4'd6 && i_idx <= IDX_ULT_TMR):
        o_addr = P_TMR_BASE + w_idx8 - 8'd6;
      default:
        o_addr = P_CLK_BASE;
    endcase
  end

endmodule

// File: rtl/maquina_lectura.sv
// RTC read sequencer: F0h transfer, clock/timer reads, atomic publish.
module maquina_lectura
  import maquina_lectura_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       Lectura,
  input  logic       Bloqueo,
  input  logic       En_tmr,
  input  logic       DIR,
  input  logic       DAT,
  input  logic       cambio_estado,
  input  logic [7:0] Dato_Bus,
  output logic       E_lec,
  output logic [7:0] Dir_Lec,
  output logic [7:0] Seg,
  output logic [7:0] Min,
  output logic [7:0] Hora,
  output logic [7:0] Dia,
  output logic [7:0] Mes,
  output logic [7:0] Ano,
  output logic [7:0] T_Seg,
  output logic [7:0] T_Min,
  output logic [7:0] T_Hora,
  output logic       Term_Lec,
  output logic       Ocupado
);

  estado_t    r_state;
  logic [3:0] r_idx;
  logic       r_tmr_en;
  logic       r_e_lec;
  logic [7:0] r_dir;
  logic       r_term;
  logic [7:0] r_dato_tmp;
  logic [7:0] r_shadow [N_REGS];
  logic [7:0] r_pub    [N_REGS];

  logic [7:0] w_addr;
  logic       w_ultimo;

  tabla_dir_lectura #(
    .P_CLK_BASE (CLK_BASE),
    .P_TMR_BASE (TMR_BASE)
  ) u_tabla (
    .i_idx  (r_idx),
    .o_addr (w_addr)
  );

  assign w_ultimo = (r_idx == IDX_ULT_TMR) ||
                    ((r_idx == IDX_ULT_CLK) && !r_tmr_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_tmr_en   <= 1'b0;
      r_e_lec    <= 1'b0;
      r_dir      <= '0;
      r_term     <= 1'b0;
      r_dato_tmp <= '0;
      for (int i = 0; i < N_REGS; i++) begin
        r_shadow[i] <= '0;
        r_pub[i]    <= '0;
      end
    end else begin
      r_term <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_e_lec <= 1'b0;
          if (Lectura && !Bloqueo) begin
            r_state  <= S_CMD;
            r_e_lec  <= 1'b1;
            r_tmr_en <= En_tmr;
          end
        end
        S_CMD, S_READ: begin
          // strobe priority: DIR, then DAT, then cambio_estado
          if (DIR) begin
            r_e_lec <= 1'b1;
            r_dir   <= (r_state == S_CMD) ? ADDR_TRANSF : w_addr;
          end else if (DAT) begin
            r_e_lec <= 1'b1;
            if (r_state == S_READ)
              r_dato_tmp <= Dato_Bus;
          end else if (cambio_estado) begin
            r_e_lec <= 1'b0;
            if (r_state == S_CMD) begin
              r_idx   <= '0;
              r_state <= S_READ;
            end else begin
              r_shadow[r_idx] <= r_dato_tmp;
              if (w_ultimo)
                r_state <= S_DONE;
              else
                r_idx <= r_idx + 4'd1;
            end
          end else begin
            r_e_lec <= 1'b1;
          end
        end
        S_DONE: begin
          for (int i = 0; i < 6; i++)
            r_pub[i] <= r_shadow[i];
          if (r_tmr_en)
            for (int i = 6; i < N_REGS; i++)
              r_pub[i] <= r_shadow[i];
          r_term  <= 1'b1;
          r_e_lec <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_e_lec <= 1'b0;
        end
      endcase
    end
  end

  assign E_lec    = r_e_lec;
  assign Dir_Lec  = r_dir;
  assign Term_Lec = r_term;
  assign Ocupado  = (r_state != S_IDLE);

  assign Seg    = r_pub[0];
  assign Min    = r_pub[1];
  assign Hora   = r_pub[2];
  assign Dia    = r_pub[3];
  assign Mes    = r_pub[4];
  assign Ano    = r_pub[5];
  assign T_Seg  = r_pub[6];
  assign T_Min  = r_pub[7];
  assign T_Hora = r_pub[8];

endmodule
